// File: rtl/pixel_out_fifo.sv
// pixel_out_fifo: 512-entry framed RGB565 output buffer feeding the VGA driver.
// Pixels are admitted only inside a frame (sop..eop). The downstream side pulls
// with b_rdy and sees the pixel one cycle later.
// Optional frame-length checking is enabled by defining PIXEL_FIFO_FRAME_CHECK_EN.
module pixel_out_fifo #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              b_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [ADDR_W-1:0] dout_usedw,
  output logic              overflow,
  output logic              underflow,
  output logic              frame_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WORD_W = DATA_W + 2;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] count;
  logic              full;
  logic              empty;
  logic              wr_try;
  logic              wr_en;
  logic              wr_drop;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] mem [DEPTH];

  // One slot is kept free so the count fits in ADDR_W bits.
  assign full    = (count == {ADDR_W{1'b1}});
  assign empty   = (count == '0);
  assign wr_en   = wr_try && !full;
  assign wr_drop = wr_try && full;
  assign rd_en   = b_rdy && !empty;
  assign rd_word = mem[rd_ptr];
  assign dout_usedw = count;

  // Input framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOP;
    else        state <= state_nxt;
  end

  // Frame admission: decide whether this pixel is a write attempt and where framing goes next.
  always_comb begin
    state_nxt = state;
    wr_try    = 1'b0;
    case (state)
      WAIT_SOP: begin
        if (din_vld && din_sop) begin
          wr_try    = 1'b1;
          state_nxt = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (din_vld) wr_try = 1'b1;
      end
      default: state_nxt = WAIT_SOP;
    endcase
    // A dropped pixel loses the frame, so resync at the next sop; eop closes the frame.
    if (wr_try && (full || din_eop)) state_nxt = WAIT_SOP;
  end

  // Pixel storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {din_sop, din_eop, din};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && !rd_en)      count <= count + ADDR_W'(1);
      else if (rd_en && !wr_en) count <= count - ADDR_W'(1);
    end
  end

  // Registered read port; dout keeps its last pixel when nothing is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= rd_en;
      dout_sop <= rd_en && rd_word[DATA_W+1];
      dout_eop <= rd_en && rd_word[DATA_W];
      if (rd_en) dout <= rd_word[DATA_W-1:0];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_drop)         overflow  <= 1'b1;
      if (b_rdy && empty)  underflow <= 1'b1;
    end
  end

`ifdef PIXEL_FIFO_FRAME_CHECK_EN
  localparam int unsigned FCNT_W = 19;

  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] frame_cnt_nxt_c;

  // Length including the current pixel; sop restarts the count.
  always_comb begin
    frame_cnt_nxt_c = frame_cnt + FCNT_W'(1);
    if (din_sop) frame_cnt_nxt_c = FCNT_W'(1);
  end

  // Frame length counter (dropped pixels still count) and sticky length error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else if (wr_try) begin
      frame_cnt <= frame_cnt_nxt_c;
      if (din_sop && (state == IN_FRAME)) frame_err <= 1'b1;
      if (din_eop && (frame_cnt_nxt_c != FCNT_W'(FRAME_PIXELS))) frame_err <= 1'b1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_out_fifo.sv
// Self-checking bench for pixel_out_fifo: directed scenarios plus randomized
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_pixel_out_fifo;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned FP     = 16;
  localparam int unsigned CAP    = 511;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] px;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_vld = 1'b0;
  logic              din_sop = 1'b0;
  logic              din_eop = 1'b0;
  logic              b_rdy = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_sop;
  logic              dout_eop;
  logic [ADDR_W-1:0] dout_usedw;
  logic              overflow;
  logic              underflow;
  logic              frame_err;

  pixel_out_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .b_rdy(b_rdy), .dout(dout), .dout_vld(dout_vld),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_usedw(dout_usedw),
    .overflow(overflow), .underflow(underflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ent_t              q[$];
  bit                m_in_frame;
  int                m_fcnt;
  logic [DATA_W-1:0] e_dout;
  bit                e_vld, e_sop, e_eop, e_ovf, e_unf, e_ferr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("dout_vld", 32'(dout_vld), 32'(e_vld));
    chk("dout_sop", 32'(dout_sop), 32'(e_sop));
    chk("dout_eop", 32'(dout_eop), 32'(e_eop));
    chk("dout", 32'(dout), 32'(e_dout));
    chk("usedw", 32'(dout_usedw), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("underflow", 32'(underflow), 32'(e_unf));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
  endtask

  // Apply one cycle of stimulus, advance the model, then compare.
  task automatic cyc(input logic vld, input logic sop, input logic eop,
                     input logic rdy, input logic [DATA_W-1:0] px);
    bit   m_full;
    bit   m_empty;
    bit   m_try;
    ent_t ent;
    din = px; din_vld = vld; din_sop = sop; din_eop = eop; b_rdy = rdy;
    @(posedge clk);
    m_full  = (q.size() == CAP);
    m_empty = (q.size() == 0);
    m_try   = vld && (m_in_frame || sop);
    if (rdy && !m_empty) begin
      ent    = q.pop_front();
      e_vld  = 1'b1;
      e_sop  = ent.sop;
      e_eop  = ent.eop;
      e_dout = ent.px;
    end else begin
      e_vld = 1'b0;
      e_sop = 1'b0;
      e_eop = 1'b0;
    end
    if (rdy && m_empty) e_unf = 1'b1;
    if (m_try) begin
`ifdef PIXEL_FIFO_FRAME_CHECK_EN
      if (sop) begin
        if (m_in_frame) e_ferr = 1'b1;
        m_fcnt = 1;
      end else begin
        m_fcnt++;
      end
      if (eop && m_fcnt != int'(FP)) e_ferr = 1'b1;
`endif
      if (m_full) begin
        e_ovf      = 1'b1;
        m_in_frame = 1'b0;
      end else begin
        ent = '{sop: sop, eop: eop, px: px};
        q.push_back(ent);
        m_in_frame = !eop;
      end
    end
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; b_rdy = 1'b0;
    rst_n = 1'b0;
    #3;
    q.delete();
    m_in_frame = 1'b0; m_fcnt = 0;
    e_dout = '0; e_vld = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
    e_ovf = 1'b0; e_unf = 1'b0; e_ferr = 1'b0;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frame of n pixels, optionally with reads alongside.
  task automatic frame(input int n, input logic rdy, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++)
      cyc(1'b1, i == 0, i == n - 1, rdy, base + DATA_W'(i));
  endtask

  task automatic idle_read(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    int p_vld;
    int p_rdy;
    int p_fr;
    @(negedge clk);
    do_reset();

    // Leading pixels without sop are discarded, then a 4-pixel frame.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'hdead);
    for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, i == 3, 1'b0, 16'h1111 * DATA_W'(i + 1));
    chk("usedw_after_frame", 32'(dout_usedw), 32'd4);
    // Drain with four back-to-back pulls, then one more on empty.
    idle_read(4);
    chk("last_px", 32'(dout), 32'h4444);
    idle_read(1);
    chk("underflow_on_empty", 32'(underflow), 32'd1);

    // Overflow: 520 pixels into an empty FIFO, no reads.
    do_reset();
    for (int i = 0; i < 520; i++) cyc(1'b1, i == 0, 1'b0, 1'b0, DATA_W'(i));
    chk("usedw_full", 32'(dout_usedw), 32'(CAP));
    chk("overflow_set", 32'(overflow), 32'd1);
    frame(5, 1'b0, 16'h7000);
    idle_read(CAP);
    frame(5, 1'b0, 16'h8000);
    idle_read(6);

    // Steady state at 100 entries with simultaneous write and read.
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1'b1, i == 0, 1'b0, 1'b0, DATA_W'(i));
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, DATA_W'(100 + i));
    chk("usedw_steady", 32'(dout_usedw), 32'd100);
    // Reset mid-frame discards everything.
    do_reset();
    idle_read(2);

    // Frame length checking.
    do_reset();
    frame(15, 1'b0, 16'h0100);
`ifdef PIXEL_FIFO_FRAME_CHECK_EN
    chk("ferr_short", 32'(frame_err), 32'd1);
`else
    chk("ferr_short", 32'(frame_err), 32'd0);
`endif
    do_reset();
    frame(16, 1'b1, 16'h0200);
    chk("ferr_exact", 32'(frame_err), 32'd0);
    frame(4, 1'b0, 16'h0300);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0400);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0401);

    // Randomized traffic in phases of varying input/output pressure.
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      p_vld = $urandom_range(10, 100);
      p_rdy = $urandom_range(0, 100);
      p_fr  = $urandom_range(8, 60);
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, 99) < p_vld,
            $urandom_range(0, p_fr) == 0,
            $urandom_range(0, p_fr) == 0,
            $urandom_range(0, 99) < p_rdy,
            DATA_W'($urandom));
      end
    end
    idle_read(CAP + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
